ahb_slave_if_multi: RTL

// Parametrised AHB slave front-end for the AHB-to-APB bridge. It decodes a contiguous address

---
 rtl/ahb_slave_if_multi.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ahb_slave_if_multi.sv
// AHB slave front-end for the AHB-to-APB bridge: window decode into one-hot selects,
// two-stage address/data/direction pipeline, wait-state pass-through and ERROR response.
module ahb_slave_if_multi #(
    parameter int unsigned            ADDR_W      = 32,
    parameter int unsigned            DATA_W      = 32,
    parameter int unsigned            NUM_SLV     = 3,
    parameter logic [ADDR_W-1:0]      BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned            REGION_LOG2 = 26
) (
    input  logic                Hclk,
    input  logic                Hresetn,
    input  logic                Hwrite,
    input  logic                Hreadyin,
    input  logic [1:0]          Htrans,
    input  logic [ADDR_W-1:0]   Haddr,
    input  logic [DATA_W-1:0]   Hwdata,
    input  logic [DATA_W-1:0]   Prdata,
    input  logic                bridge_rdy,
    output logic                valid,
    output logic [NUM_SLV-1:0]  tempselx,
    output logic [ADDR_W-1:0]   Haddr1,
    output logic [ADDR_W-1:0]   Haddr2,
    output logic [DATA_W-1:0]   Hwdata1,
    output logic [DATA_W-1:0]   Hwdata2,
    output logic                Hwritereg,
    output logic                Hwritereg2,
    output logic [DATA_W-1:0]   Hrdata,
    output logic                Hreadyout,
    output logic [1:0]          Hresp
);

    // Upper bound held one bit wider so a window ending at the top of the map never wraps.
    localparam logic [ADDR_W:0] WIN_END =
        {1'b0, BASE_ADDR} + ((ADDR_W+1)'(NUM_SLV) << REGION_LOG2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   haddr1_q, haddr1_d, haddr2_q, haddr2_d;
    logic [DATA_W-1:0]   hwdata1_q, hwdata1_d, hwdata2_q, hwdata2_d;
    logic                hwrite1_q, hwrite1_d, hwrite2_q, hwrite2_d;

    logic                in_win;
    logic                illegal;
    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   idx;

    always_comb begin
        in_win   = (Haddr >= BASE_ADDR) && ({1'b0, Haddr} < WIN_END);
        offset   = Haddr - BASE_ADDR;
        idx      = offset >> REGION_LOG2;
        tempselx = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            tempselx[i] = in_win && (idx == ADDR_W'(i));
        end
        valid    = Hreadyin & Htrans[1] & in_win;
        illegal  = Hreadyin & Htrans[1] & ~in_win;
    end

    always_comb begin
        haddr1_d  = haddr1_q;
        haddr2_d  = haddr2_q;
        hwdata1_d = hwdata1_q;
        hwdata2_d = hwdata2_q;
        hwrite1_d = hwrite1_q;
        hwrite2_d = hwrite2_q;
        if (Hreadyin) begin
            haddr1_d  = Haddr;
            haddr2_d  = haddr1_q;
            hwdata1_d = Hwdata;
            hwdata2_d = hwdata1_q;
            hwrite1_d = Hwrite;
            hwrite2_d = hwrite1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        Hresp     = 2'b00;
        Hreadyout = bridge_rdy;
        case (state_q)
            ST_IDLE: begin
                if (illegal) state_d = ST_ERR1;
            end
            ST_ERR1: begin
                Hresp     = 2'b01;
                Hreadyout = 1'b0;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                Hresp     = 2'b01;
                Hreadyout = 1'b1;
                state_d   = illegal ? ST_ERR1 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= ST_IDLE;
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite1_q <= 1'b0;
            hwrite2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            haddr1_q  <= haddr1_d;
            haddr2_q  <= haddr2_d;
            hwdata1_q <= hwdata1_d;
            hwdata2_q <= hwdata2_d;
            hwrite1_q <= hwrite1_d;
            hwrite2_q <= hwrite2_d;
        end
    end

    assign Haddr1     = haddr1_q;
    assign Haddr2     = haddr2_q;
    assign Hwdata1    = hwdata1_q;
    assign Hwdata2    = hwdata2_q;
    assign Hwritereg  = hwrite1_q;
    assign Hwritereg2 = hwrite2_q;
    assign Hrdata     = Prdata;

endmodule
